// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR core: a single signed MAC walks all TAPS sample/coefficient pairs
// per accepted input, then rounds and saturates the sum into a valid/ready output register.
module fir_serial_mac #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0,
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS),
  localparam int IDX_W    = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  // Half-LSB bias of the post-shift result; zero when no shift is applied.
  localparam logic signed [ACC_W:0] RND_BIAS =
    (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [IDX_W:0]        TAPS_N   = (IDX_W+1)'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE,
    S_OUT
  } state_t;

  state_t                   state, next_state;
  logic signed [DATA_W-1:0] x_line [TAPS];
  logic signed [COEF_W-1:0] coef   [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    acc_rnd;
  logic [OUT_W-1:0]         sat_val;
  logic                     accept;
  logic                     coef_wr;

  assign in_ready  = (state == S_IDLE);
  assign coef_busy = (state != S_IDLE);
  assign accept    = in_ready && in_valid && !flush;
  assign coef_wr   = in_ready && coef_we && ({1'b0, coef_addr} < TAPS_N);

  assign prod    = x_line[idx] * coef[idx];
  assign acc_rnd = ($signed({acc[ACC_W-1], acc}) + RND_BIAS) >>> OUT_SHIFT;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sat_val = acc_rnd[OUT_W-1:0];
    if (acc_rnd > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (acc_rnd < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_MAC;
      S_MAC:   if (idx == LAST_IDX) next_state = S_DONE;
      S_DONE:  next_state = S_OUT;
      S_OUT:   if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: the delay line and coefficient arrays are reset explicitly because filtering
  // starts from a known all-zero history and all-zero taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x_line[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) x_line[k] <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_line[0] <= in_data;
            for (int k = 1; k < TAPS; k++) x_line[k] <= x_line[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + IDX_W'(1);
        end
        S_DONE: begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Taps survive flush; a write in the accepting cycle is visible to the MAC that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: two instances (OUT_SHIFT 0 and 1) share stimulus and are checked
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_fir_serial_mac;

  localparam int TAPS = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              flush     = 1'b0;
  logic              coef_we   = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic [7:0]        coef_data = '0;
  logic              in_valid  = 1'b0;
  logic [7:0]        in_data   = '0;
  logic              out_ready = 1'b1;
  logic              in_ready0, in_ready1, coef_busy0, coef_busy1, out_valid0, out_valid1;
  logic signed [7:0] out_data0, out_data1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fir_serial_mac u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy0),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready)
  );

  fir_serial_mac #(.OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy1),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output: plain dot product, then round-half-up shift and clamp to 8 bits.
  function automatic longint fin(input longint a, input int sh);
    longint r;
    r = a;
    if (sh > 0) r = (a + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r;
  endfunction

  // Transaction model: busy from accept until the output is taken; the result is known at accept.
  logic              m_busy, m_ov;
  int                m_t;
  logic signed [7:0] m_h [TAPS];
  logic signed [7:0] m_x [TAPS];
  longint            m_y0, m_y1;
  logic signed [7:0] hh  [TAPS];
  logic signed [7:0] xs  [TAPS];
  longint            sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ov   <= 1'b0;
      m_t    <= 0;
      m_y0   <= 0;
      m_y1   <= 0;
      for (int k = 0; k < TAPS; k++) begin
        m_h[k] <= '0;
        m_x[k] <= '0;
      end
    end else begin
      hh = m_h;
      if (!m_busy && coef_we) hh[coef_addr] = coef_data;
      m_h <= hh;
      if (flush) begin
        m_busy <= 1'b0;
        m_ov   <= 1'b0;
        for (int k = 0; k < TAPS; k++) m_x[k] <= '0;
      end else if (!m_busy) begin
        if (in_valid) begin
          xs[0] = in_data;
          for (int k = 1; k < TAPS; k++) xs[k] = m_x[k-1];
          sum = 0;
          for (int k = 0; k < TAPS; k++) sum += longint'(hh[k]) * longint'(xs[k]);
          m_x    <= xs;
          m_y0   <= fin(sum, 0);
          m_y1   <= fin(sum, 1);
          m_busy <= 1'b1;
          m_t    <= 0;
        end
      end else if (!m_ov) begin
        if (m_t == TAPS) m_ov <= 1'b1;
        m_t <= m_t + 1;
      end else if (out_ready) begin
        m_ov   <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready0", in_ready0, !m_busy);
    check("in_ready1", in_ready1, !m_busy);
    check("coef_busy0", coef_busy0, m_busy);
    check("coef_busy1", coef_busy1, m_busy);
    check("out_valid0", out_valid0, m_ov);
    check("out_valid1", out_valid1, m_ov);
    if (m_ov) begin
      check("out_data0", out_data0, m_y0);
      check("out_data1", out_data1, m_y1);
    end
  end

  task automatic write_coef(input int k, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(k);
    coef_data = 8'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic accept_sample(input logic [7:0] x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 100, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_output(output logic signed [7:0] y0, output logic signed [7:0] y1);
    int n;
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("output_timeout", n < 100, 1);
    y0 = out_data0;
    y1 = out_data1;
    @(negedge clk);
  endtask

  initial begin
    logic signed [7:0] y0, y1;
    logic signed [7:0] imp_exp [9];
    int acc_q[$];
    int ov_q[$];
    int n;
    imp_exp = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_data", out_data0, 0);
    check("rst_in_ready", in_ready0, 1);
    check("rst_coef_busy", coef_busy0, 0);

    // Impulse response reads back the taps in order.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < 9; i++) begin
      accept_sample((i == 0) ? 8'd1 : 8'd0);
      get_output(y0, y1);
      check("impulse", y0, imp_exp[i]);
    end

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    accept_sample(8'd3);
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_out", out_valid0, 1);
    for (int c = 0; c < 5; c++) begin
      check("bp_data0_stable", out_data0, 3);
      check("bp_data1_stable", out_data1, 2);
      check("bp_in_ready_low", in_ready0, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", out_valid0, 0);
    check("bp_released_ready", in_ready0, 1);

    // Continuous traffic: accept period and output latency.
    in_valid = 1'b1;
    in_data  = '0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready0) acc_q.push_back(c);
      if (out_valid0) ov_q.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("lat_accept_count", acc_q.size(), 6);
    for (int i = 1; i < acc_q.size(); i++)
      check("accept_period", acc_q[i] - acc_q[i-1], TAPS + 3);
    for (int i = 0; i < ov_q.size(); i++)
      check("out_latency", ov_q[i] - acc_q[i], TAPS + 2);
    get_output(y0, y1);

    // Flush at MAC index 3 drops the result and clears history.
    accept_sample(8'd5);
    get_output(y0, y1);
    accept_sample(8'd5);
    get_output(y0, y1);
    accept_sample(8'd5);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (out_valid0) n++;
    end
    check("flush_no_output", n, 0);
    check("flush_idle", in_ready0, 1);

    // Coefficient write while busy must be ignored.
    accept_sample(8'd1);
    check("busy_during_mac", coef_busy0, 1);
    write_coef(0, 99);
    get_output(y0, y1);
    check("post_flush_y0", y0, 1);
    check("post_flush_y1", y1, 1);
    accept_sample(8'd0);
    get_output(y0, y1);
    check("post_flush_y0_next", y0, 2);

    // Saturation in both directions.
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int i = 0; i < 8; i++) begin
      accept_sample(8'd127);
      get_output(y0, y1);
    end
    check("sat_pos0", y0, 127);
    check("sat_pos1", y1, 127);
    for (int i = 0; i < 8; i++) begin
      accept_sample(8'h80);
      get_output(y0, y1);
    end
    check("sat_neg0", y0, -128);
    check("sat_neg1", y1, -128);

    // Rounding on the shifted instance.
    write_coef(0, 3);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    accept_sample(8'd1);
    get_output(y0, y1);
    check("rnd_pos1", y1, 2);
    check("rnd_pos0", y0, 3);
    accept_sample(8'hFF);
    get_output(y0, y1);
    check("rnd_neg1", y1, -1);
    check("rnd_neg0", y0, -3);

    // Reset pulse while presenting a result.
    out_ready = 1'b0;
    accept_sample(8'd7);
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstp_reached_out", out_valid0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstp_out_valid0", out_valid0, 0);
    check("rstp_out_valid1", out_valid1, 0);
    check("rstp_out_data", out_data0, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      flush     = ($urandom_range(0, 49) == 0);
      coef_we   = !flush && ($urandom_range(0, 9) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      coef_data = 8'($urandom);
      if (!(in_valid && !in_ready0)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    flush     = 1'b0;
    coef_we   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
